// File: rtl/prog_clock_divider.sv
// Programmable clock divider: period N and high time H, with shadowed reload
// applied on the period boundary (or immediately while the divider is frozen).
module prog_clock_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic [WIDTH-1:0] high_value,
  output logic             clocko,
  output logic             tick,
  output logic             pending,
  output logic             load_ack
);

  localparam logic [WIDTH-1:0] RST_N_C = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_H_C = WIDTH'(DEFAULT_DIV / 2);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C  = WIDTH'(0);

  logic [WIDTH-1:0] n_act_q, n_act_d, h_act_q, h_act_d;
  logic [WIDTH-1:0] n_sh_q, n_sh_d, h_sh_q, h_sh_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clocko_q, clocko_d, tick_q, tick_d;
  logic             pending_q, pending_d, load_ack_q, load_ack_d;
  logic [WIDTH-1:0] load_n_s;
  logic             wrap_s;

  assign load_n_s = (div_value == ZERO_C) ? ONE_C : div_value;
  assign wrap_s   = (cnt_q == (n_act_q - ONE_C));

  // Next-state logic for counter, active/shadow settings and strobes.
  always_comb begin
    n_act_d    = n_act_q;
    h_act_d    = h_act_q;
    n_sh_d     = n_sh_q;
    h_sh_d     = h_sh_q;
    cnt_d      = cnt_q;
    clocko_d   = clocko_q;
    tick_d     = 1'b0;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    if (div_load) begin
      n_sh_d = load_n_s;
      h_sh_d = high_value;
    end else begin
      n_sh_d = n_sh_q;
      h_sh_d = h_sh_q;
    end
    if (!enable) begin
      // Frozen divider: a load takes effect at once and parks cnt on the wrap.
      if (div_load) begin
        n_act_d    = load_n_s;
        h_act_d    = high_value;
        cnt_d      = load_n_s - ONE_C;
        clocko_d   = 1'b0;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else begin
        load_ack_d = 1'b0;
      end
    end else begin
      if (wrap_s) begin
        cnt_d  = ZERO_C;
        tick_d = 1'b1;
        if (div_load) begin
          n_act_d    = load_n_s;
          h_act_d    = high_value;
          pending_d  = 1'b0;
          load_ack_d = 1'b1;
        end else if (pending_q) begin
          n_act_d    = n_sh_q;
          h_act_d    = h_sh_q;
          pending_d  = 1'b0;
          load_ack_d = 1'b1;
        end else begin
          load_ack_d = 1'b0;
        end
      end else begin
        cnt_d  = cnt_q + ONE_C;
        tick_d = 1'b0;
        if (div_load) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      clocko_d = (cnt_d < h_act_d);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      n_act_q    <= RST_N_C;
      h_act_q    <= RST_H_C;
      n_sh_q     <= RST_N_C;
      h_sh_q     <= RST_H_C;
      cnt_q      <= RST_N_C - ONE_C;
      clocko_q   <= 1'b0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      n_act_q    <= n_act_d;
      h_act_q    <= h_act_d;
      n_sh_q     <= n_sh_d;
      h_sh_q     <= h_sh_d;
      cnt_q      <= cnt_d;
      clocko_q   <= clocko_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign clocko   = clocko_q;
  assign tick     = tick_q;
  assign pending  = pending_q;
  assign load_ack = load_ack_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed table-driven bench for prog_clock_divider (WIDTH=16, DEFAULT_DIV=10).
// Each row is one clock edge: inputs, then expected {clocko,tick,pending,load_ack}.
module tb_prog_clock_divider;

  logic        clock = 1'b0;
  logic        reset_n, enable, div_load;
  logic [15:0] div_value, high_value;
  logic        clocko, tick, pending, load_ack;

  typedef struct {
    logic        rn;
    logic        en;
    logic        ld;
    logic [15:0] dv;
    logic [15:0] hv;
    logic [3:0]  exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   waited   = 0;

  prog_clock_divider #(.WIDTH(16), .DEFAULT_DIV(10)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .div_load(div_load),
    .div_value(div_value), .high_value(high_value), .clocko(clocko),
    .tick(tick), .pending(pending), .load_ack(load_ack)
  );

  always #5 clock = ~clock;

  task automatic add(input logic rn, input logic en, input logic ld,
                     input int dv, input int hv, input logic [3:0] exp,
                     input int reps, input string tag);
    vec_t v;
    v.rn = rn; v.en = en; v.ld = ld; v.dv = 16'(dv); v.hv = 16'(hv);
    v.exp = exp; v.tag = tag;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  // Plain enabled cycles with no load.
  task automatic run(input logic [3:0] exp, input int reps, input string tag);
    add(1'b1, 1'b1, 1'b0, 0, 0, exp, reps, tag);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; div_load = 1'b0;
    div_value = 16'd0; high_value = 16'd0;

    // Reset with load asserted: reset wins.
    add(1'b0, 1'b0, 1'b1, 3, 1, 4'b0000, 2, "reset");
    // Default 10-cycle period: tick on first enabled edge, high 5 / low 5.
    for (int p = 0; p < 4; p++) begin
      run(4'b1100, 1, "def_wrap");
      run(4'b1000, 4, "def_high");
      run(4'b0000, 5, "def_low");
    end
    run(4'b1100, 1, "def_wrap");
    run(4'b1000, 3, "def_high");
    // Load N=4,H=1 at cnt=3: pending until wrap at cnt=9.
    add(1'b1, 1'b1, 1'b1, 4, 1, 4'b1010, 1, "ld4_cap");
    run(4'b0010, 5, "ld4_pend");
    run(4'b1101, 1, "ld4_apply");
    for (int p = 0; p < 2; p++) begin
      run(4'b0000, 3, "n4_low");
      run(4'b1100, 1, "n4_wrap");
    end
    // N=0 clamps to 1 with H=5: tick and clocko stay high.
    add(1'b1, 1'b1, 1'b1, 0, 5, 4'b0010, 1, "ld0_cap");
    run(4'b0010, 2, "ld0_pend");
    run(4'b1101, 1, "n1_apply");
    run(4'b1100, 2, "n1_h5");
    // H=0 load lands on a wrap edge: applied directly, clocko stays 0.
    add(1'b1, 1'b1, 1'b1, 1, 0, 4'b0101, 1, "h0_apply");
    run(4'b0100, 2, "n1_h0");
    // Back to N=10,H=5, then two loads in one period: only N=8,H=2 applies.
    add(1'b1, 1'b1, 1'b1, 10, 5, 4'b1101, 1, "n10_apply");
    run(4'b1000, 1, "n10_c1");
    add(1'b1, 1'b1, 1'b1, 6, 3, 4'b1010, 1, "ld6_cap");
    run(4'b1010, 1, "ld6_pend");
    add(1'b1, 1'b1, 1'b1, 8, 2, 4'b1010, 1, "ld8_cap");
    run(4'b0010, 5, "ld8_pend");
    run(4'b1101, 1, "n8_apply");
    run(4'b1000, 1, "n8_high");
    run(4'b0000, 6, "n8_low");
    run(4'b1100, 1, "n8_wrap");
    run(4'b1000, 1, "n8_high2");
    run(4'b0000, 6, "n8_low2");
    // Load on the wrap edge: applied at once, pending never set.
    add(1'b1, 1'b1, 1'b1, 10, 5, 4'b1101, 1, "wrap_ld");
    run(4'b1000, 3, "n10_high");
    // Freeze for 7 cycles at cnt=3.
    add(1'b1, 1'b0, 1'b0, 0, 0, 4'b1000, 7, "frozen");
    run(4'b1000, 1, "thaw_c4");
    run(4'b0000, 1, "thaw_c5");
    // Load N=3,H=2 while disabled: ack next cycle, first enabled edge wraps.
    add(1'b1, 1'b0, 1'b1, 3, 2, 4'b0001, 1, "dis_ld");
    run(4'b1100, 1, "dis_wrap");
    run(4'b1000, 1, "n3_high");
    run(4'b0000, 1, "n3_low");
    run(4'b1100, 1, "n3_wrap");
    // Restore N=10, then reset with pending=1 at cnt=6.
    add(1'b1, 1'b1, 1'b1, 10, 5, 4'b1010, 1, "n10_cap");
    run(4'b0010, 1, "n10_pend");
    run(4'b1101, 1, "n10_apply2");
    run(4'b1000, 2, "n10_c12");
    add(1'b1, 1'b1, 1'b1, 4, 1, 4'b1010, 1, "ldr_cap");
    run(4'b1010, 1, "ldr_c4");
    run(4'b0010, 2, "ldr_c56");
    add(1'b0, 1'b1, 1'b0, 0, 0, 4'b0000, 1, "mid_reset");
    run(4'b1100, 1, "rst_wrap");
    run(4'b1000, 4, "rst_high");
    run(4'b0000, 5, "rst_low");
    run(4'b1100, 1, "rst_wrap2");

    foreach (vecs[i]) begin
      reset_n    = vecs[i].rn;
      enable     = vecs[i].en;
      div_load   = vecs[i].ld;
      div_value  = vecs[i].dv;
      high_value = vecs[i].hv;
      @(posedge clock);
      #1;
      n_checks++;
      if ({clocko, tick, pending, load_ack} !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL %s row %0d: {clocko,tick,pending,load_ack} got %b expected %b",
                 vecs[i].tag, i, {clocko, tick, pending, load_ack}, vecs[i].exp);
      end
    end

    reset_n    = 1'b0;
    enable     = 1'b1;
    div_load   = 1'b1;
    div_value  = 16'd3;
    high_value = 16'd1;
    @(posedge clock);
    #1;
    n_checks++;
    if ({clocko, tick, pending, load_ack} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: {clocko,tick,pending,load_ack} got %b expected 0000",
               {clocko, tick, pending, load_ack});
    end

    reset_n  = 1'b1;
    div_load = 1'b0;
    enable   = 1'b1;
    waited   = 0;
    while ((tick !== 1'b1) && (waited < 20)) begin
      @(posedge clock);
      #1;
      waited++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_tick: no tick within %0d cycles after reset release", waited);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
  WIDTH        16   width of counter, period and high-time registers
  DEFAULT_DIV  10   period after reset, in clock cycles; legal range 1 to 2^WIDTH-1
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
  clock       in   1      single clock; all logic is on its rising edge
  reset_n     in   1      synchronous, active-low reset
  enable      in   1      count enable; low freezes the divider
  div_load    in   1      one-cycle request to load new settings
  div_value   in   WIDTH  new period N, in cycles
  high_value  in   WIDTH  new high time H, in cycles
  clocko      out  1      divided clock, registered
  tick        out  1      one-cycle strobe at each period start, registered
  pending     out  1      a loaded setting is waiting for the period boundary
  load_ack    out  1      one-cycle strobe when a new setting takes effect
REQ-003 There is one clock and reset_n is synchronous, active-low; no other clock or asynchronous input SHALL exist.

Function
REQ-004 The block SHALL hold these internal registers: active period N_act, active high time H_act, shadow period N_sh, shadow high time H_sh, and counter cnt. All are WIDTH bits.
REQ-005 An enabled cycle is any rising edge with enable=1.
  - If cnt==N_act-1, the edge SHALL wrap: cnt<=0 and tick<=1.
  - Otherwise cnt<=cnt+1 and tick<=0.
REQ-006 On every enabled edge, clocko SHALL be set to (cnt_next < H_act_next), using an unsigned compare.
  - H=0 gives clocko constantly 0.
  - H>=N gives clocko constantly 1.
REQ-007 When enable=0, the following SHALL hold their values: cnt, clocko, N_act and H_act. tick SHALL be 0.
REQ-008 On div_load=1, the shadow SHALL capture N_sh<=div_value and H_sh<=high_value.
  - A div_value of 0 SHALL be clamped to 1.
REQ-009 A div_load while pending=1 SHALL overwrite the shadow; only the last value loaded is ever applied.
REQ-010 While enable=1, a pending setting SHALL be applied only on a wrap edge. The new N and H take effect for the period that starts at that edge, and for the clocko value computed on that edge.
REQ-011 If div_load and a wrap happen on the same edge, the incoming div_value/high_value SHALL be applied at that wrap directly. They bypass the shadow.
REQ-012 If div_load=1 while enable=0, the setting SHALL be applied on the same edge. On that edge:
  - cnt<=N_new-1
  - clocko<=0
  - load_ack<=1
  - pending stays 0
REQ-013 pending SHALL go to 1 on the edge that captures a load which is not applied on that same edge. It SHALL go to 0 on the edge that applies the load.
REQ-014 load_ack SHALL be 1 for exactly the one cycle after each edge that applies a setting. It is 0 otherwise.
REQ-015 N_act=1 SHALL wrap on every enabled edge: tick stays high continuously, and clocko=(H_act>=1).
REQ-016 The divided period SHALL be exactly N_act enabled cycles. clocko SHALL be high for min(H_act, N_act) of those cycles, starting at the wrap edge.
REQ-017 There SHALL be no combinational path from any input to any output.

Reset
REQ-018 On an edge with reset_n=0, the registers SHALL take these values, regardless of any other input:
  - N_act=N_sh=DEFAULT_DIV
  - H_act=H_sh=DEFAULT_DIV/2 (integer division)
  - cnt=DEFAULT_DIV-1
  - clocko=0, tick=0, pending=0, load_ack=0
REQ-019 Because of REQ-018, the first enabled edge after reset SHALL be a wrap, giving tick=1 and clocko=1 (when H_act>=1).
REQ-020 A reset asserted mid-period or with pending=1 SHALL discard the shadow setting. No load_ack SHALL be generated for it.

Verification
REQ-021 A bench SHALL cover at least these directed scenarios (DEFAULT_DIV=10, WIDTH=16):
  - Reset, then enable=1 for 40 cycles -> tick once every 10 cycles; clocko high 5 cycles then low 5; first tick on the first enabled edge.
  - div_load with N=4, H=1 at cnt=3 -> pending=1 until the wrap at cnt=9; then load_ack for one cycle; then 4-cycle periods with clocko high for 1 cycle.
  - div_load with N=0, H=5 -> N clamped to 1; tick stays high; clocko stays 1. A following load with H=0 -> clocko stays 0 and tick continues.
  - Two loads (N=6, then N=8) within one period -> only N=8 is applied, with one load_ack. A load on the wrap edge -> applied on that edge, with pending never set.
  - enable=0 for 7 cycles mid-period -> cnt, clocko and the period phase are frozen and tick=0. A load while disabled (N=3, H=2) -> load_ack next cycle; the first enabled edge is a wrap.
  - reset_n=0 for 1 cycle with pending=1 at cnt=6 -> all outputs take reset values, the shadow is discarded, and the 10-cycle behaviour resumes.
